exe_adder_commit: RTL and testbench
===================================

Name: exe_adder_commit

Overview:
- Execute-stage commit buffer directly downstream of the 32-bit adder/comparator.
- Captures adder result, carry-out and compare flag per accepted operation into a 2-entry skid FIFO toward write-back.
- Holds the architectural SR flag and carry bits, which feed the adder's flagIn/carryIn.
- Decouples adder issue from write-back stalls, supports pipeline flush and SPR (mtspr) writes of flag/carry.

Parameters:
- DEPTH, 2, FIFO entries; fixed at 2; other values unsupported.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- sValid  in  1  adder operation valid.
- sReady  out  1  commit buffer can accept.
- sResult  in  32  adder result.
- sCarry  in  1  adder carryOut.
- sFlag  in  1  adder flagOut.
- sWe  in  1  operation writes register file.
- sDest  in  REG_ADDR_W  destination register.
- sUpdFlag  in  1  operation updates SR flag.
- sUpdCarry  in  1  operation updates SR carry.
- flush  in  1  discard all buffered and incoming operations.
- sprWe  in  1  mtspr write of flag/carry.
- sprFlag  in  1  value for flag on sprWe.
- sprCarry  in  1  value for carry on sprWe.
- flagOut  out  1  architectural flag (to adder flagIn).
- carryOut  out  1  architectural carry (to adder carryIn).
- mValid  out  1  head entry valid to write-back.
- mReady  in  1  write-back accepts head.
- mResult  out  32  head result.
- mWe  out  1  head register-write enable.
- mDest  out  REG_ADDR_W  head destination.

Behaviour:
- Reset (nReset low, asynchronous):
  - occupancy=0; mValid=0; mResult=0; mWe=0; mDest=0; flagOut=0; carryOut=0.
  - sReady=1 once reset deasserts.
  - Reset mid-transfer drops all entries; no partial state survives.
- Accept:
  - push = sValid & sReady & ~flush.
  - sReady = (occupancy<2). Registered-state only; no combinational path from mReady.
- Pop: pop = mValid & mReady. mValid = (occupancy>0). Head fields are driven from registered storage.
- Latency and throughput:
  - An entry pushed in cycle N is visible on mValid/mResult in cycle N+1 when the FIFO was empty.
  - Sustained throughput is 1 op/cycle with mReady held high.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Occupancy transitions:
  - push only: +1.
  - pop only: -1.
  - push+pop: unchanged, and the new entry is queued behind the head.
  - At occupancy 2, sReady=0, so push is impossible; a pop frees a slot with sReady=1 next cycle.
  - At occupancy 0, mValid=0, so pop is impossible.
- Flag/carry commit:
  - Updated at push time, not at pop, so the next adder op in cycle N+1 sees the new values.
  - On push: flagOut <= sFlag if sUpdFlag; carryOut <= sCarry if sUpdCarry. Each bit is independent.
  - If the same cycle has sprWe and a push, the push's enabled bits win. Bits the push does not update take sprFlag/sprCarry.
  - sprWe alone writes both bits.
- flush:
  - Next cycle: occupancy=0 and mValid=0.
  - The incoming op that cycle is discarded; its flag/carry update is also suppressed.
  - flagOut/carryOut keep previously committed values; no rollback.
  - sprWe in a flush cycle still takes effect.
  - A pop coinciding with flush is still consumed by write-back; the entry counts as retired.
- Storage: head/tail pointers are 1-bit and wrap modulo 2. Pointer wrap must not corrupt the entry still held in the other slot.

Test Plan:
- Reset, then push {result=0x0000_0005, we=1, dest=3} with mReady=1 → next cycle mValid=1, mResult=0x5, mDest=3; cycle after, mValid=0.
- mReady=0, push 0x11, 0x22, attempt 0x33 → sReady=0 after second push; 0x33 is not accepted. Raise mReady → outputs 0x11 then 0x22 in consecutive cycles; sReady returns to 1.
- Push sFlag=1,sUpdFlag=1,sCarry=1,sUpdCarry=0 → flagOut=1 next cycle, carryOut unchanged 0. Then sprWe with sprFlag=0,sprCarry=1 → flag=0, carry=1.
- Same cycle: sprWe (sprFlag=0, sprCarry=0) plus push (sFlag=1,sUpdFlag=1,sUpdCarry=0), prior carry=1 → flagOut=1, carryOut=0.
- Occupancy 2, assert flush with sValid=1,sUpdFlag=1,sFlag=1 (prior flag=0) → next cycle mValid=0, sReady=1, flagOut stays 0.
- Stream 8 ops (0x1..0x8) with mReady toggling 1,0,1,1,0,... → all eight values appear on mResult in order, none lost or duplicated. Assert nReset low mid-stream → mValid=0 and flag/carry=0 immediately.

Source files
------------

// File: rtl/exe_adder_commit_if.sv
// Issue-side and write-back-side handshake bundle of the execute-stage commit buffer.
// The adder pipeline drives it through master; the commit buffer uses slave.
interface exe_adder_commit_if #(
  parameter int unsigned REG_ADDR_W = 5
) ();
  logic                  sValid;
  logic                  sReady;
  logic [31:0]           sResult;
  logic                  sCarry;
  logic                  sFlag;
  logic                  sWe;
  logic [REG_ADDR_W-1:0] sDest;
  logic                  sUpdFlag;
  logic                  sUpdCarry;
  logic                  mValid;
  logic                  mReady;
  logic [31:0]           mResult;
  logic                  mWe;
  logic [REG_ADDR_W-1:0] mDest;

  modport master (
    output sValid, sResult, sCarry, sFlag, sWe, sDest, sUpdFlag, sUpdCarry, mReady,
    input  sReady, mValid, mResult, mWe, mDest
  );

  modport slave (
    input  sValid, sResult, sCarry, sFlag, sWe, sDest, sUpdFlag, sUpdCarry, mReady,
    output sReady, mValid, mResult, mWe, mDest
  );
endinterface

// File: rtl/exe_adder_commit.sv
// Two-entry skid FIFO between the adder and write-back.
// It also holds the architectural SR flag/carry bits that feed back into the adder.
module exe_adder_commit #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                clock,
  input  logic                nReset,
  exe_adder_commit_if.slave   bus,
  input  logic                flush,
  input  logic                sprWe,
  input  logic                sprFlag,
  input  logic                sprCarry,
  output logic                flagOut,
  output logic                carryOut
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OCC_W  = 2;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic                  we;
    logic [REG_ADDR_W-1:0] dest;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           head;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             ready_q;
  logic             valid_q;
  logic             flag_d;
  logic             carry_d;
  logic             push_c;
  logic             pop_c;

  // A flushed op is dropped entirely, including its flag/carry side effects.
  assign push_c = bus.sValid & ready_q & ~flush;
  assign pop_c  = valid_q & bus.mReady;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      case ({push_c, pop_c})
        2'b10:   occ_d = OCC_W'(occ_q + OCC_W'(1));
        2'b01:   occ_d = OCC_W'(occ_q - OCC_W'(1));
        default: occ_d = occ_q;
      endcase
    end
  end

  // SPR write lands first so the push's enabled bits take priority over it.
  always_comb begin
    flag_d  = flagOut;
    carry_d = carryOut;
    if (sprWe) begin
      flag_d  = sprFlag;
      carry_d = sprCarry;
    end
    if (push_c && bus.sUpdFlag)  flag_d  = bus.sFlag;
    if (push_c && bus.sUpdCarry) carry_d = bus.sCarry;
  end

  // Handshake flags are registered from the next occupancy, so sReady never
  // depends combinationally on mReady.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      occ_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      flagOut  <= 1'b0;
      carryOut <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      occ_q    <= occ_d;
      ready_q  <= (occ_d < OCC_W'(DEPTH));
      valid_q  <= (occ_d != '0);
      flagOut  <= flag_d;
      carryOut <= carry_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push_c) begin
          mem_q[wr_ptr_q] <= '{result: bus.sResult, we: bus.sWe, dest: bus.sDest};
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign bus.sReady  = ready_q;
  assign bus.mValid  = valid_q;
  assign bus.mResult = head.result;
  assign bus.mWe     = head.we;
  assign bus.mDest   = head.dest;
endmodule

// File: tb/tb_exe_adder_commit.sv
// Directed bench for exe_adder_commit: a queue-based reference model checked every cycle,
// plus literal expectations taken from the hand-worked scenarios.
module tb_exe_adder_commit;
  logic clock = 1'b0;
  logic nReset;
  logic flush, sprWe, sprFlag, sprCarry;
  logic flagOut, carryOut;

  exe_adder_commit_if #(.REG_ADDR_W(5)) bus ();

  exe_adder_commit #(.DEPTH(2), .REG_ADDR_W(5)) dut (
    .clock    (clock),
    .nReset   (nReset),
    .bus      (bus),
    .flush    (flush),
    .sprWe    (sprWe),
    .sprFlag  (sprFlag),
    .sprCarry (sprCarry),
    .flagOut  (flagOut),
    .carryOut (carryOut)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] r;
    logic        we;
    logic [4:0]  d;
  } ent_t;

  ent_t        mq[$];
  logic        m_flag, m_carry;
  logic [31:0] dut_ret[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, flag/carry as plain bits.
  always @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      mq.delete();
      m_flag  = 1'b0;
      m_carry = 1'b0;
    end else begin
      automatic bit push = bus.sValid && (mq.size() < 2) && !flush;
      automatic bit pop  = (mq.size() > 0) && bus.mReady;
      if (pop) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (push) mq.push_back('{r: bus.sResult, we: bus.sWe, d: bus.sDest});
      if (sprWe) begin
        m_flag  = sprFlag;
        m_carry = sprCarry;
      end
      if (push && bus.sUpdFlag)  m_flag  = bus.sFlag;
      if (push && bus.sUpdCarry) m_carry = bus.sCarry;
    end
  end

  // Values actually retired by the DUT, in order.
  always @(posedge clock) begin
    if (nReset && bus.mValid && bus.mReady) dut_ret.push_back(bus.mResult);
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (nReset) begin
      chk("mValid", 32'(bus.mValid), 32'(mq.size() > 0));
      chk("sReady", 32'(bus.sReady), 32'(mq.size() < 2));
      chk("flagOut", 32'(flagOut), 32'(m_flag));
      chk("carryOut", 32'(carryOut), 32'(m_carry));
      if (mq.size() > 0) begin
        chk("mResult", bus.mResult, mq[0].r);
        chk("mWe", 32'(bus.mWe), 32'(mq[0].we));
        chk("mDest", 32'(bus.mDest), 32'(mq[0].d));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.sValid    = 1'b0;
    bus.sResult   = '0;
    bus.sCarry    = 1'b0;
    bus.sFlag     = 1'b0;
    bus.sWe       = 1'b0;
    bus.sDest     = '0;
    bus.sUpdFlag  = 1'b0;
    bus.sUpdCarry = 1'b0;
    flush         = 1'b0;
    sprWe         = 1'b0;
    sprFlag       = 1'b0;
    sprCarry      = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] r, input logic we, input logic [4:0] d,
                        input logic f, input logic uf, input logic c, input logic uc);
    bus.sValid    = 1'b1;
    bus.sResult   = r;
    bus.sWe       = we;
    bus.sDest     = d;
    bus.sFlag     = f;
    bus.sUpdFlag  = uf;
    bus.sCarry    = c;
    bus.sUpdCarry = uc;
  endtask

  logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    nReset     = 1'b0;
    bus.mReady = 1'b0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mValid", 32'(bus.mValid), 32'd0);
    chk("rst_mResult", bus.mResult, 32'd0);
    chk("rst_mDest", 32'(bus.mDest), 32'd0);
    chk("rst_flag", 32'(flagOut), 32'd0);
    chk("rst_carry", 32'(carryOut), 32'd0);
    nReset = 1'b1;
    step();
    chk("rst_sReady", 32'(bus.sReady), 32'd1);

    // Single op, empty FIFO: visible next cycle, gone the cycle after.
    bus.mReady = 1'b1;
    set_op(32'h5, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    chk("t1_mValid", 32'(bus.mValid), 32'd1);
    chk("t1_mResult", bus.mResult, 32'h5);
    chk("t1_mDest", 32'(bus.mDest), 32'd3);
    step();
    chk("t1_drained", 32'(bus.mValid), 32'd0);

    // Fill to two, third push refused, then drain in order.
    bus.mReady = 1'b0;
    set_op(32'h11, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_op(32'h22, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t2_full_sReady", 32'(bus.sReady), 32'd0);
    set_op(32'h33, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    chk("t2_head", bus.mResult, 32'h11);
    bus.mReady = 1'b1;
    step();
    chk("t2_second", bus.mResult, 32'h22);
    chk("t2_sReady_back", 32'(bus.sReady), 32'd1);
    step();
    chk("t2_empty", 32'(bus.mValid), 32'd0);
    chk("t2_ret_cnt", 32'(dut_ret.size()), 32'd3);
    if (dut_ret.size() == 3) begin
      chk("t2_ret0", dut_ret[0], 32'h5);
      chk("t2_ret1", dut_ret[1], 32'h11);
      chk("t2_ret2", dut_ret[2], 32'h22);
    end

    // Independent flag/carry update on push, then SPR write.
    set_op(32'h30, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    chk("t3_flag", 32'(flagOut), 32'd1);
    chk("t3_carry", 32'(carryOut), 32'd0);
    sprWe = 1'b1; sprFlag = 1'b0; sprCarry = 1'b1;
    step();
    idle();
    chk("t3_spr_flag", 32'(flagOut), 32'd0);
    chk("t3_spr_carry", 32'(carryOut), 32'd1);

    // SPR and push together: push wins the flag, SPR supplies carry.
    set_op(32'h40, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    sprWe = 1'b1; sprFlag = 1'b0; sprCarry = 1'b0;
    step();
    idle();
    chk("t4_flag", 32'(flagOut), 32'd1);
    chk("t4_carry", 32'(carryOut), 32'd0);
    step();

    // Flush at occupancy 2 with a flag-updating op in flight.
    sprWe = 1'b1; sprFlag = 1'b0; sprCarry = 1'b0;
    step();
    idle();
    bus.mReady = 1'b0;
    set_op(32'hA1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_op(32'hA2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_op(32'hA3, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    idle();
    chk("t5_mValid", 32'(bus.mValid), 32'd0);
    chk("t5_sReady", 32'(bus.sReady), 32'd1);
    chk("t5_flag", 32'(flagOut), 32'd0);

    // Stream 1..8 with a stuttering write-back.
    dut_ret.delete();
    begin
      int idx = 0;
      for (int c = 0; c < 80; c++) begin
        automatic bit acc;
        if (dut_ret.size() == 8) break;
        bus.mReady = pat[c % 5];
        if (idx < 8) set_op(32'(idx + 1), 1'b1, 5'(idx), 1'b0, 1'b0, 1'b0, 1'b0);
        else idle();
        acc = bus.sValid && bus.sReady;
        step();
        if (acc) idx++;
      end
    end
    idle();
    chk("t6_ret_cnt", 32'(dut_ret.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < dut_ret.size()) chk("t6_order", dut_ret[i], 32'(i + 1));
    end

    // Asynchronous reset with entries and flag/carry held.
    bus.mReady = 1'b0;
    set_op(32'h50, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_op(32'h51, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    sprWe = 1'b1; sprFlag = 1'b1; sprCarry = 1'b1;
    step();
    idle();
    chk("t7_pre_flag", 32'(flagOut), 32'd1);
    chk("t7_pre_mValid", 32'(bus.mValid), 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    chk("t7_mValid", 32'(bus.mValid), 32'd0);
    chk("t7_flag", 32'(flagOut), 32'd0);
    chk("t7_carry", 32'(carryOut), 32'd0);
    chk("t7_mResult", bus.mResult, 32'd0);
    step();
    step();
    nReset = 1'b1;
    step();
    chk("t7_after_mValid", 32'(bus.mValid), 32'd0);
    chk("t7_after_sReady", 32'(bus.sReady), 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
